// File: rtl/select_not_pipe.sv
// select_not_pipe: registered NOT(s ? b : a) with valid/ready, select modes and a saturating beat counter; SELECT_NOT_PIPE_PARITY_EN adds q_par
module select_not_pipe #(
  parameter int WIDTH       = 8,
  parameter int AUTO_PERIOD = 4,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             s,
  input  logic [1:0]       mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] q,
  output logic             q_sel,
  output logic [CNT_W-1:0] beat_cnt
`ifdef SELECT_NOT_PIPE_PARITY_EN
  ,
  output logic             q_par
`endif
);
  localparam logic [7:0] LAST = 8'(AUTO_PERIOD - 1);
  logic       sel_st;
  logic [7:0] per_cnt;
  logic       acc;
  logic       esel;
  logic [WIDTH-1:0] nq;
  assign in_ready = !out_valid || out_ready;
  assign acc      = in_valid && in_ready;
  assign esel     = mode[1] ? mode[0] : (mode[0] ? sel_st : s);
  assign nq       = ~(esel ? b : a);
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      q         <= '0;
      q_sel     <= 1'b0;
      beat_cnt  <= '0;
      sel_st    <= 1'b0;
      per_cnt   <= '0;
    end else if (acc) begin
      out_valid <= 1'b1;
      q         <= nq;
      q_sel     <= esel;
      if (beat_cnt != '1) beat_cnt <= beat_cnt + 1'b1;
      if (mode != 2'b01) per_cnt <= '0;
      else if (per_cnt == LAST) begin
        per_cnt <= '0;
        sel_st  <= ~sel_st;
      end else per_cnt <= per_cnt + 8'd1;
    end else if (out_ready) out_valid <= 1'b0;
  end
`ifdef SELECT_NOT_PIPE_PARITY_EN
  always_ff @(posedge clk or posedge rst)
    if (rst) q_par <= 1'b0;
    else if (acc) q_par <= ^nq;
`endif
endmodule

// File: tb/tb_select_not_pipe.sv
// tb_select_not_pipe: directed literal checks plus randomized traffic against a behavioural model
module tb_select_not_pipe;
  localparam int P = 4;
  localparam int CMAX = 15;
  logic clk = 0, rst = 1;
  logic in_valid = 0, out_ready = 0, s = 0;
  logic [1:0] mode = 0;
  logic [7:0] a = 0, b = 0;
  logic in_ready, out_valid, q_sel;
  logic [7:0] q;
  logic [3:0] beat_cnt;
`ifdef SELECT_NOT_PIPE_PARITY_EN
  logic q_par;
`endif
  int n_chk = 0, n_fail = 0;
  select_not_pipe #(.WIDTH(8), .AUTO_PERIOD(P), .CNT_W(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .s(s), .mode(mode), .out_valid(out_valid),
    .out_ready(out_ready), .q(q), .q_sel(q_sel), .beat_cnt(beat_cnt)
`ifdef SELECT_NOT_PIPE_PARITY_EN
    , .q_par(q_par)
`endif
  );
  always #5 clk = ~clk;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask
  // Model: auto select = value held on entry, flipped once per P accepted auto beats
  logic m_valid, m_sel, m_base, e;
  logic [7:0] m_q;
  int m_cnt, m_run;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_valid = 0; m_q = 0; m_sel = 0; m_cnt = 0; m_base = 0; m_run = 0;
    end else if (in_valid && (!m_valid || out_ready)) begin
      if (mode == 2'b01) begin
        e = m_base ^ ((m_run / P) % 2 == 1);
        m_run++;
      end else begin
        m_base = m_base ^ ((m_run / P) % 2 == 1);
        m_run = 0;
        e = (mode == 2'b00) ? s : mode[0];
      end
      m_q = ~(e ? b : a);
      m_sel = e;
      m_valid = 1;
      m_cnt = (m_cnt < CMAX) ? m_cnt + 1 : CMAX;
    end else if (out_ready) m_valid = 0;
  end
  always @(negedge clk) begin
    chk("in_ready", in_ready, !m_valid || out_ready);
    chk("out_valid", out_valid, m_valid);
    chk("q", q, m_q);
    chk("q_sel", q_sel, m_sel);
    chk("beat_cnt", beat_cnt, m_cnt);
`ifdef SELECT_NOT_PIPE_PARITY_EN
    chk("q_par", q_par, ^m_q);
`endif
  end
  task automatic drive(input logic v, input logic [7:0] av, input logic [7:0] bv,
                       input logic sv, input logic [1:0] mv, input logic r);
    in_valid = v; a = av; b = bv; s = sv; mode = mv; out_ready = r;
    @(posedge clk); #1;
  endtask
  initial begin
    logic exp_sel [10] = '{0, 0, 0, 0, 1, 1, 1, 1, 0, 0};
    logic exp_sw [8] = '{0, 0, 0, 0, 0, 0, 0, 1};
    logic [1:0] sw_mode [8] = '{1, 1, 2, 1, 1, 1, 1, 1};
    repeat (2) @(posedge clk);
    #1;
    chk("rst out_valid", out_valid, 0);
    chk("rst q", q, 0);
    chk("rst beat_cnt", beat_cnt, 0);
    rst = 0;
    drive(1, 8'h3C, 8'hA5, 0, 0, 1);
    chk("m00 valid", out_valid, 1);
    chk("m00 q s0", q, 8'hC3);
    chk("m00 sel s0", q_sel, 0);
    drive(1, 8'h3C, 8'hA5, 1, 0, 1);
    chk("m00 q s1", q, 8'h5A);
    chk("m00 sel s1", q_sel, 1);
    drive(1, 8'h3C, 8'hA5, 0, 0, 1);
    out_ready = 0; s = 1;
    #1 chk("bp in_ready", in_ready, 0);
    for (int i = 0; i < 3; i++) begin
      drive(1, 8'h3C, 8'hA5, 1, 0, 0);
      chk("bp q held", q, 8'hC3);
      chk("bp cnt held", beat_cnt, 3);
    end
    out_ready = 1;
    #1 chk("bp release", in_ready, 1);
    drive(1, 8'h3C, 8'hA5, 1, 0, 1);
    chk("bp next q", q, 8'h5A);
    chk("bp next cnt", beat_cnt, 4);
    for (int i = 0; i < 10; i++) begin
      drive(1, 8'h00, 8'hFF, 0, 1, 1);
      chk("auto sel", q_sel, exp_sel[i]);
      chk("auto q", q, exp_sel[i] ? 8'h00 : 8'hFF);
    end
    drive(1, 8'h00, 8'hFF, 0, 1, 1);
    drive(1, 8'h00, 8'hFF, 0, 1, 1);
    chk("sat at 16 beats", beat_cnt, 15);
    rst = 1;
    #1;
    chk("async out_valid", out_valid, 0);
    chk("async q", q, 0);
    chk("async q_sel", q_sel, 0);
    chk("async beat_cnt", beat_cnt, 0);
    @(posedge clk); #1 rst = 0;
    for (int i = 0; i < 8; i++) begin
      drive(1, 8'h5A, 8'hFF, 1, sw_mode[i], 1);
      chk("switch sel", q_sel, exp_sw[i]);
    end
    for (int i = 0; i < 12; i++) begin
      drive(1, 8'h0F, 8'hF0, 0, 2, 1);
      chk("sat cnt", beat_cnt, (i + 9 > CMAX) ? CMAX : i + 9);
    end
`ifdef SELECT_NOT_PIPE_PARITY_EN
    drive(1, 8'h01, 8'h00, 0, 0, 1);
    chk("par q FE", q, 8'hFE);
    chk("par 1", q_par, 1);
    drive(1, 8'h03, 8'h00, 0, 0, 1);
    chk("par q FC", q, 8'hFC);
    chk("par 0", q_par, 0);
`endif
    drive(0, 0, 0, 0, 0, 1);
    chk("drain valid", out_valid, 0);
    for (int i = 0; i < 3000; i++) begin
      rst = ($urandom_range(0, 299) == 0);
      drive($urandom_range(0, 3) != 0, 8'($urandom), 8'($urandom), 1'($urandom),
            ($urandom_range(0, 2) == 0) ? 2'($urandom) : 2'b01, $urandom_range(0, 3) != 0);
    end
    rst = 0;
    @(posedge clk); #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/select_not_pipe.md
Name: select_not_pipe

Overview:
Parametrised, registered successor to the 8-bit inverting 2:1 select used in the pseudo-random datapath. Each accepted beat computes Q = NOT(s ? B : A) over WIDTH bits and holds it in an output register behind a valid/ready handshake. Adds select modes (external, auto-alternating, forced A, forced B) and a saturating beat counter. Sits between the generator's state registers and its output combiner.

Parameters:
WIDTH, 8, data width of A, B and Q
AUTO_PERIOD, 4, accepted beats between select toggles in auto mode; legal range 1..255
CNT_W, 16, width of the beat counter

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-high reset
in_valid  in  1  A/B/s beat valid
in_ready  out  1  block can accept a beat
a  in  WIDTH  operand selected when effective select = 0
b  in  WIDTH  operand selected when effective select = 1
s  in  1  external select, used in mode 00
mode  in  2  00 external, 01 auto-alternate, 10 force A, 11 force B
out_valid  out  1  q holds an unconsumed result
out_ready  in  1  downstream accepts q
q  out  WIDTH  registered NOT(selected operand)
q_sel  out  1  effective select used for the current q
beat_cnt  out  CNT_W  number of accepted beats, saturating

Behaviour:
- Reset (async assert, sync release): out_valid=0, q=0, q_sel=0, beat_cnt=0, auto select state sel_st=0, period counter per_cnt=0.
- in_ready = !out_valid || out_ready (combinational). Accept = in_valid && in_ready.
- Effective select esel: mode 00 -> s; 01 -> sel_st; 10 -> 0; 11 -> 1.
- On accept: q <= ~(esel ? b : a); q_sel <= esel; out_valid <= 1. Latency: 1 cycle from accept to out_valid.
- No accept and out_ready && out_valid: out_valid <= 0; q and q_sel keep their values.
- Simultaneous consume and accept: new beat replaces old; out_valid stays 1. Full throughput, 1 beat/cycle.
- out_valid && !out_ready: in_ready=0; q, q_sel stable until consumed.
- Auto mode (mode=01), on each accept: if per_cnt == AUTO_PERIOD-1, then per_cnt <= 0 and sel_st <= ~sel_st; else per_cnt <= per_cnt+1. The toggle applies from the next accepted beat, so the current beat uses the pre-toggle sel_st.
- In any mode other than 01: per_cnt <= 0; sel_st holds its value. Re-entering 01 resumes with the held sel_st and a full period.
- beat_cnt: +1 per accept; saturates at 2^CNT_W-1, no wrap.
- mode and s are sampled only on accepted beats; changes while stalled have no effect on the held q.
- Reset asserted mid-stream: the pending q is discarded and all state returns to reset values immediately.

Optional Feature:
SELECT_NOT_PIPE_PARITY_EN:
- Defined: extra output port q_par (1 bit), registered alongside q. q_par = XOR-reduce of the new q on accept. Reset value 0. Holds with q while stalled.
- Undefined: port q_par is absent. No parity logic is present.

Test Plan:
- Mode 00, WIDTH=8: a=0x3C, b=0xA5. Accept s=0, then s=1 -> q=0xC3 (q_sel=0), then q=0x5A (q_sel=1); out_valid rises 1 cycle after each accept.
- Backpressure: out_ready=0 for 3 cycles with in_valid=1 -> in_ready=0, q held at 0xC3, beat_cnt unchanged. Release out_ready -> in_ready=1 the same cycle; next beat accepted.
- Mode 01, AUTO_PERIOD=4: 10 back-to-back beats, a=0x00, b=0xFF -> q_sel sequence 0,0,0,0,1,1,1,1,0,0; q = 0xFF ×4, 0x00 ×4, 0xFF ×2.
- Mode switch: 2 beats in 01, 1 beat in 10, then back to 01 -> the 10-mode beat has q_sel=0; per_cnt restarts, so 4 more beats are needed before the next toggle.
- Saturation: CNT_W=4, 20 accepts -> beat_cnt stops at 15. Assert rst mid-burst -> out_valid, q, beat_cnt, sel_st all 0 without waiting for a clock edge.
- With SELECT_NOT_PIPE_PARITY_EN defined: a=0x01, s=0 -> q=0xFE, q_par=1. a=0x03 -> q=0xFC, q_par=0.
